mem_request_initiator: RTL and testbench
========================================

MEM_REQUEST_INITIATOR -- requirements
Module: mem_request_initiator

Interface
REQ-001 SHALL have parameter RESP_LATENCY, default 1: cycles from request cycle to the cycle the peripheral response is sampled; legal range 1..15.
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on posedge.
REQ-003 SHALL have port aresetn, input, 1: reset, synchronous, active-low.
REQ-004 SHALL have port i_cmd_valid, input, 1: core command present.
REQ-005 SHALL have port o_cmd_ready, output, 1: command accepted when valid and ready are both high.
REQ-006 SHALL have port i_cmd_addr, input, `ADDR_W: byte address.
REQ-007 SHALL have port i_cmd_count, input, `MEM_COUNT_W: NONE/BYTE/HALF/WORD.
REQ-008 SHALL have port i_cmd_we, input, 1: 1 means store, 0 means load.
REQ-009 SHALL have port i_cmd_unsigned, input, 1: load zero-extends when 1, sign-extends when 0.
REQ-010 SHALL have port i_cmd_wr_data, input, `WORD_W: store data, right-aligned.
REQ-011 SHALL have port o_req_addr, output, `ADDR_W: peripheral request address.
REQ-012 SHALL have port o_req_count, output, `MEM_COUNT_W: peripheral request size; `MEM_COUNT_NONE when idle.
REQ-013 SHALL have port o_req_we, output, 1: peripheral write enable.
REQ-014 SHALL have port o_req_wr_data, output, `WORD_W: peripheral write data.
REQ-015 SHALL have port i_res_rd_data, input, `WORD_W: peripheral read data, right-aligned.
REQ-016 SHALL have port i_res_code, input, `MEM_CODE_W: peripheral result code.
REQ-017 SHALL have port o_rsp_valid, output, 1: result available to core.
REQ-018 SHALL have port o_rsp_data, output, `WORD_W: extended load data.
REQ-019 SHALL have port o_rsp_code, output, `MEM_CODE_W: result code.
REQ-020 SHALL have port i_rsp_ready, input, 1: core consumes result when valid and ready are both high.

Function
REQ-021 SHALL implement FSM IDLE, REQ, WAIT, DONE; o_cmd_ready = 1 only in IDLE and while aresetn is high.
REQ-022 SHALL, on acceptance in IDLE, latch addr, count, we, unsigned and wr_data; later changes on cmd inputs SHALL be ignored until the next acceptance.
REQ-023 SHALL precheck the latched command: count NONE -> DONE, code `MEM_CODE_INVALID; HALF with addr[0]=1, or WORD with addr[1:0]!=0 -> DONE, code `MEM_CODE_MISALIGNED; in both cases data 0 and no request issued; otherwise -> REQ.
REQ-024 SHALL in REQ drive o_req_* from the latched command for exactly one cycle, then -> WAIT.
REQ-025 SHALL drive o_req_count `MEM_COUNT_NONE and o_req_addr, o_req_we, o_req_wr_data at 0 outside REQ.
REQ-026 SHALL count in WAIT so that i_res_* is sampled on the cycle RESP_LATENCY cycles after the REQ cycle, then -> DONE.
REQ-027 SHALL pass the sampled code through unchanged as o_rsp_code.
REQ-028 SHALL form o_rsp_data only for a load returning `MEM_CODE_READ: BYTE extends bit 7, HALF extends bit 15 (zero when unsigned, sign otherwise), WORD passes through; all other cases give 0.
REQ-029 SHALL hold o_rsp_valid, o_rsp_data and o_rsp_code stable in DONE until i_rsp_ready; the handshake cycle -> IDLE, and o_rsp_valid falls the next cycle.
REQ-030 SHALL not overlap commands: minimum command-to-command spacing is precheck + REQ + RESP_LATENCY + 1 (DONE) + 1 (IDLE) cycles.

Reset
REQ-031 SHALL on aresetn low at a clock edge: state IDLE, o_cmd_ready 0 while low, o_req_count `MEM_COUNT_NONE, o_req_addr/we/wr_data 0, o_rsp_valid 0, o_rsp_data 0, o_rsp_code `MEM_CODE_INVALID.
REQ-032 SHALL on reset in any state discard the in-flight command and any pending response; the first cycle after release accepts a new command.

Verification
REQ-033 SHALL cover: load BYTE, addr 0x5, signed, peripheral returns 0x80 code READ -> o_rsp_data 0xFFFFFF80, code READ.
REQ-034 SHALL cover: load HALF, addr 0x2, unsigned, return 0x8001 -> o_rsp_data 0x00008001; exactly one REQ cycle observed.
REQ-035 SHALL cover: WORD command at addr 0x6 -> o_req_count stays NONE throughout, o_rsp_code MISALIGNED, data 0.
REQ-036 SHALL cover: store WORD 0xDEADBEEF at 0x10 -> o_req_we 1 and o_req_wr_data 0xDEADBEEF for one cycle, o_rsp_data 0.
REQ-037 SHALL cover: i_rsp_ready held low 5 cycles -> response held stable 5 cycles, o_cmd_ready 0 until the handshake completes.
REQ-038 SHALL cover: aresetn low during WAIT -> outputs at REQ-031 values, no o_rsp_valid for the dropped command; with RESP_LATENCY=3, sampling occurs 3 cycles after REQ.

Source files
------------

// File: rtl/mem_request_initiator_if.sv
// -----------------------------------------------------------------------------
// mem_request_initiator_if
//
// Purpose: groups the core command channel, the peripheral request/response
// bus and the core response channel of mem_request_initiator into one bundle.
// Signal names keep the i_/o_ prefixes as seen from the initiator.
//
// Modports:
//   slave  - used by mem_request_initiator (i_* inputs, o_* outputs)
//   master - used by the environment driving the initiator (mirror image)
//
// Shared encodings (defined once here, guarded so every file may repeat them):
//   ADDR_W / WORD_W      : 32-bit byte address and data word
//   MEM_COUNT_*          : access size NONE/BYTE/HALF/WORD
//   MEM_CODE_*           : result codes INVALID/READ/WRITE/MISALIGNED/FAULT
// -----------------------------------------------------------------------------
`ifndef MEM_REQ_INIT_DEFS_DONE
`define MEM_REQ_INIT_DEFS_DONE
`define ADDR_W             32
`define WORD_W             32
`define MEM_COUNT_W        2
`define MEM_COUNT_NONE     2'd0
`define MEM_COUNT_BYTE     2'd1
`define MEM_COUNT_HALF     2'd2
`define MEM_COUNT_WORD     2'd3
`define MEM_CODE_W         3
`define MEM_CODE_INVALID   3'd0
`define MEM_CODE_READ      3'd1
`define MEM_CODE_WRITE     3'd2
`define MEM_CODE_MISALIGNED 3'd3
`define MEM_CODE_FAULT     3'd4
`endif

interface mem_request_initiator_if;
  // Core command channel
  logic                    i_cmd_valid;
  logic                    o_cmd_ready;
  logic [`ADDR_W-1:0]      i_cmd_addr;
  logic [`MEM_COUNT_W-1:0] i_cmd_count;
  logic                    i_cmd_we;
  logic                    i_cmd_unsigned;
  logic [`WORD_W-1:0]      i_cmd_wr_data;
  // Peripheral request
  logic [`ADDR_W-1:0]      o_req_addr;
  logic [`MEM_COUNT_W-1:0] o_req_count;
  logic                    o_req_we;
  logic [`WORD_W-1:0]      o_req_wr_data;
  // Peripheral response
  logic [`WORD_W-1:0]      i_res_rd_data;
  logic [`MEM_CODE_W-1:0]  i_res_code;
  // Core response channel
  logic                    o_rsp_valid;
  logic [`WORD_W-1:0]      o_rsp_data;
  logic [`MEM_CODE_W-1:0]  o_rsp_code;
  logic                    i_rsp_ready;

  modport slave (
    input  i_cmd_valid, i_cmd_addr, i_cmd_count, i_cmd_we, i_cmd_unsigned,
           i_cmd_wr_data, i_res_rd_data, i_res_code, i_rsp_ready,
    output o_cmd_ready, o_req_addr, o_req_count, o_req_we, o_req_wr_data,
           o_rsp_valid, o_rsp_data, o_rsp_code
  );

  modport master (
    output i_cmd_valid, i_cmd_addr, i_cmd_count, i_cmd_we, i_cmd_unsigned,
           i_cmd_wr_data, i_res_rd_data, i_res_code, i_rsp_ready,
    input  o_cmd_ready, o_req_addr, o_req_count, o_req_we, o_req_wr_data,
           o_rsp_valid, o_rsp_data, o_rsp_code
  );
endinterface

// File: rtl/mem_request_initiator.sv
// -----------------------------------------------------------------------------
// mem_request_initiator
//
// Purpose: accepts one load/store command from a core, checks it, issues a
// single-cycle request to a fixed-latency peripheral, samples the response
// RESP_LATENCY cycles after the request, extends load data and holds the
// result for the core until it is consumed. One command in flight at a time.
//
// Ports:
//   clk          - clock, all state changes on posedge
//   aresetn      - synchronous active-low reset
//   bus          - mem_request_initiator_if.slave (command, request,
//                  response and result signals)
//   dbg_state_o  - current FSM state (IDLE=0, REQ=1, WAIT=2, DONE=3)
//
// Handshakes: a command transfers on a cycle where i_cmd_valid and
// o_cmd_ready are both high; a result transfers on a cycle where o_rsp_valid
// and i_rsp_ready are both high. Neither valid depends on the matching ready.
// -----------------------------------------------------------------------------
`ifndef MEM_REQ_INIT_DEFS_DONE
`define MEM_REQ_INIT_DEFS_DONE
`define ADDR_W             32
`define WORD_W             32
`define MEM_COUNT_W        2
`define MEM_COUNT_NONE     2'd0
`define MEM_COUNT_BYTE     2'd1
`define MEM_COUNT_HALF     2'd2
`define MEM_COUNT_WORD     2'd3
`define MEM_CODE_W         3
`define MEM_CODE_INVALID   3'd0
`define MEM_CODE_READ      3'd1
`define MEM_CODE_WRITE     3'd2
`define MEM_CODE_MISALIGNED 3'd3
`define MEM_CODE_FAULT     3'd4
`endif

module mem_request_initiator #(
  parameter int unsigned RESP_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    aresetn,
  mem_request_initiator_if.slave  bus,
  output logic [1:0]              dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam logic [3:0] LAT_LOAD = 4'(RESP_LATENCY - 1);

  state_e                  state_q;
  // Set for the one IDLE cycle after acceptance in which the latched command
  // is checked; ready stays low during it.
  logic                    chk_q;
  logic [3:0]              cnt_q;

  logic [`ADDR_W-1:0]      cmd_addr_q;
  logic [`MEM_COUNT_W-1:0] cmd_count_q;
  logic                    cmd_we_q;
  logic                    cmd_unsigned_q;
  logic [`WORD_W-1:0]      cmd_wr_data_q;

  logic [`ADDR_W-1:0]      req_addr_q;
  logic [`MEM_COUNT_W-1:0] req_count_q;
  logic                    req_we_q;
  logic [`WORD_W-1:0]      req_wr_data_q;

  logic                    rsp_valid_q;
  logic [`WORD_W-1:0]      rsp_data_q;
  logic [`MEM_CODE_W-1:0]  rsp_code_q;

  logic                    cmd_ready;
  logic                    pre_err_d;
  logic [`MEM_CODE_W-1:0]  pre_code_d;
  logic [`WORD_W-1:0]      ext_data_d;

  // Ready is gated by aresetn directly so it is low for the whole reset.
  assign cmd_ready = aresetn && (state_q == S_IDLE) && !chk_q;

  // Precheck of the latched command.
  always_comb begin
    pre_err_d  = 1'b0;
    pre_code_d = `MEM_CODE_INVALID;
    case (cmd_count_q)
      `MEM_COUNT_NONE: begin
        pre_err_d  = 1'b1;
        pre_code_d = `MEM_CODE_INVALID;
      end
      `MEM_COUNT_HALF: begin
        pre_err_d  = cmd_addr_q[0];
        pre_code_d = `MEM_CODE_MISALIGNED;
      end
      `MEM_COUNT_WORD: begin
        pre_err_d  = |cmd_addr_q[1:0];
        pre_code_d = `MEM_CODE_MISALIGNED;
      end
      default: begin
        pre_err_d  = 1'b0;
        pre_code_d = `MEM_CODE_INVALID;
      end
    endcase
  end

  // Load data extension; only a load answered with READ produces data.
  always_comb begin
    ext_data_d = '0;
    if (!cmd_we_q && (bus.i_res_code == `MEM_CODE_READ)) begin
      case (cmd_count_q)
        `MEM_COUNT_BYTE:
          ext_data_d = {{(`WORD_W-8){!cmd_unsigned_q && bus.i_res_rd_data[7]}},
                        bus.i_res_rd_data[7:0]};
        `MEM_COUNT_HALF:
          ext_data_d = {{(`WORD_W-16){!cmd_unsigned_q && bus.i_res_rd_data[15]}},
                        bus.i_res_rd_data[15:0]};
        `MEM_COUNT_WORD:
          ext_data_d = bus.i_res_rd_data;
        default:
          ext_data_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state_q        <= S_IDLE;
      chk_q          <= 1'b0;
      cnt_q          <= '0;
      cmd_addr_q     <= '0;
      cmd_count_q    <= `MEM_COUNT_NONE;
      cmd_we_q       <= 1'b0;
      cmd_unsigned_q <= 1'b0;
      cmd_wr_data_q  <= '0;
      req_addr_q     <= '0;
      req_count_q    <= `MEM_COUNT_NONE;
      req_we_q       <= 1'b0;
      req_wr_data_q  <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_data_q     <= '0;
      rsp_code_q     <= `MEM_CODE_INVALID;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (chk_q) begin
            chk_q <= 1'b0;
            if (pre_err_d) begin
              // Rejected commands never reach the peripheral.
              state_q     <= S_DONE;
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= '0;
              rsp_code_q  <= pre_code_d;
            end else begin
              state_q       <= S_REQ;
              req_addr_q    <= cmd_addr_q;
              req_count_q   <= cmd_count_q;
              req_we_q      <= cmd_we_q;
              req_wr_data_q <= cmd_wr_data_q;
            end
          end else if (bus.i_cmd_valid && cmd_ready) begin
            chk_q          <= 1'b1;
            cmd_addr_q     <= bus.i_cmd_addr;
            cmd_count_q    <= bus.i_cmd_count;
            cmd_we_q       <= bus.i_cmd_we;
            cmd_unsigned_q <= bus.i_cmd_unsigned;
            cmd_wr_data_q  <= bus.i_cmd_wr_data;
          end
        end
        S_REQ: begin
          // Request is visible for exactly this one cycle.
          state_q       <= S_WAIT;
          req_addr_q    <= '0;
          req_count_q   <= `MEM_COUNT_NONE;
          req_we_q      <= 1'b0;
          req_wr_data_q <= '0;
          cnt_q         <= LAT_LOAD;
        end
        S_WAIT: begin
          // cnt_q reaches 0 on the cycle RESP_LATENCY cycles after REQ.
          if (cnt_q == 4'd0) begin
            state_q     <= S_DONE;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= ext_data_d;
            rsp_code_q  <= bus.i_res_code;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_DONE: begin
          if (bus.i_rsp_ready) begin
            state_q     <= S_IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.o_cmd_ready   = cmd_ready;
  assign bus.o_req_addr    = req_addr_q;
  assign bus.o_req_count   = req_count_q;
  assign bus.o_req_we      = req_we_q;
  assign bus.o_req_wr_data = req_wr_data_q;
  assign bus.o_rsp_valid   = rsp_valid_q;
  assign bus.o_rsp_data    = rsp_data_q;
  assign bus.o_rsp_code    = rsp_code_q;
  assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_mem_request_initiator.sv
`ifndef MEM_REQ_INIT_DEFS_DONE
`define MEM_REQ_INIT_DEFS_DONE
`define ADDR_W             32
`define WORD_W             32
`define MEM_COUNT_W        2
`define MEM_COUNT_NONE     2'd0
`define MEM_COUNT_BYTE     2'd1
`define MEM_COUNT_HALF     2'd2
`define MEM_COUNT_WORD     2'd3
`define MEM_CODE_W         3
`define MEM_CODE_INVALID   3'd0
`define MEM_CODE_READ      3'd1
`define MEM_CODE_WRITE     3'd2
`define MEM_CODE_MISALIGNED 3'd3
`define MEM_CODE_FAULT     3'd4
`endif

module tb_mem_request_initiator;

  localparam int LAT = 3;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       aresetn;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  mem_request_initiator_if bus ();

  mem_request_initiator #(.RESP_LATENCY(LAT)) dut (
    .clk         (clk),
    .aresetn     (aresetn),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Expected core-visible data for a load, from the sizing/extension rules.
  function automatic logic [31:0] model_load(input logic [1:0] cnt, input logic uns,
                                             input logic [31:0] rd, input logic [2:0] code,
                                             input logic we);
    longint v;
    v = 0;
    if (we || code != `MEM_CODE_READ) return 32'd0;
    case (cnt)
      `MEM_COUNT_BYTE: begin v = rd % 256;   if (!uns && v >= 128)   v = v - 256;   end
      `MEM_COUNT_HALF: begin v = rd % 65536; if (!uns && v >= 32768) v = v - 65536; end
      `MEM_COUNT_WORD: v = rd;
      default:         v = 0;
    endcase
    return v[31:0];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic scramble_cmd();
    bus.i_cmd_addr     = $urandom;
    bus.i_cmd_count    = 2'($urandom_range(0, 3));
    bus.i_cmd_we       = 1'($urandom_range(0, 1));
    bus.i_cmd_unsigned = 1'($urandom_range(0, 1));
    bus.i_cmd_wr_data  = $urandom;
  endtask

  task automatic garbage_res();
    bus.i_res_rd_data = $urandom;
    bus.i_res_code    = 3'($urandom_range(0, 7));
  endtask

  task automatic chk_reset_values(input string pfx);
    chk({pfx, "_cmd_ready"}, 32'(bus.o_cmd_ready), 32'd0);
    chk({pfx, "_req_count"}, 32'(bus.o_req_count), 32'(`MEM_COUNT_NONE));
    chk({pfx, "_req_addr"},  bus.o_req_addr, 32'd0);
    chk({pfx, "_req_we"},    32'(bus.o_req_we), 32'd0);
    chk({pfx, "_req_wdata"}, bus.o_req_wr_data, 32'd0);
    chk({pfx, "_rsp_valid"}, 32'(bus.o_rsp_valid), 32'd0);
    chk({pfx, "_rsp_data"},  bus.o_rsp_data, 32'd0);
    chk({pfx, "_rsp_code"},  32'(bus.o_rsp_code), 32'(`MEM_CODE_INVALID));
  endtask

  // One complete command: accept, observe request, answer as the peripheral
  // exactly LAT cycles after the request, then hold ready low for 'hold'
  // cycles before consuming the result.
  task automatic run_cmd(input string name, input logic [31:0] addr, input logic [1:0] cnt,
                         input logic we, input logic uns, input logic [31:0] wdata,
                         input logic [31:0] rdata, input logic [2:0] rcode, input int hold);
    int k, req_cycles, req_at, valid_at;
    logic err;
    logic [2:0] exp_code;
    logic [31:0] exp_data;

    err = 1'b0;
    exp_code = rcode;
    if (cnt == `MEM_COUNT_NONE) begin
      err = 1'b1; exp_code = `MEM_CODE_INVALID;
    end else if ((cnt == `MEM_COUNT_HALF && addr % 2 != 0) ||
                 (cnt == `MEM_COUNT_WORD && addr % 4 != 0)) begin
      err = 1'b1; exp_code = `MEM_CODE_MISALIGNED;
    end
    exp_data = err ? 32'd0 : model_load(cnt, uns, rdata, rcode, we);

    @(negedge clk);
    chk({name, "_cmd_ready_idle"}, 32'(bus.o_cmd_ready), 32'd1);
    bus.i_cmd_valid    = 1'b1;
    bus.i_cmd_addr     = addr;
    bus.i_cmd_count    = cnt;
    bus.i_cmd_we       = we;
    bus.i_cmd_unsigned = uns;
    bus.i_cmd_wr_data  = wdata;
    garbage_res();
    @(negedge clk);
    // Cycle 1 after acceptance; command inputs now change freely.
    bus.i_cmd_valid = 1'b0;
    scramble_cmd();
    k = 1; req_cycles = 0; req_at = -1; valid_at = -1;
    while (k <= 40) begin
      if (bus.o_rsp_valid) begin
        valid_at = k;
        break;
      end
      chk({name, "_cmd_ready_busy"}, 32'(bus.o_cmd_ready), 32'd0);
      if (bus.o_req_count != `MEM_COUNT_NONE) begin
        req_cycles++;
        req_at = k;
        chk({name, "_req_count"}, 32'(bus.o_req_count), 32'(cnt));
        chk({name, "_req_addr"},  bus.o_req_addr, addr);
        chk({name, "_req_we"},    32'(bus.o_req_we), 32'(we));
        chk({name, "_req_wdata"}, bus.o_req_wr_data, wdata);
      end else begin
        chk({name, "_req_idle_zero"}, bus.o_req_addr | bus.o_req_wr_data | 32'(bus.o_req_we), 32'd0);
      end
      if (req_at >= 0 && k == req_at + LAT) begin
        bus.i_res_rd_data = rdata;
        bus.i_res_code    = rcode;
      end else begin
        garbage_res();
      end
      @(negedge clk);
      k++;
    end
    chk({name, "_valid_cycle"}, 32'(valid_at), err ? 32'd2 : 32'(3 + LAT));
    chk({name, "_req_cycles"},  32'(req_cycles), err ? 32'd0 : 32'd1);
    if (!err) chk({name, "_req_cycle"}, 32'(req_at), 32'd2);
    chk({name, "_rsp_data"}, bus.o_rsp_data, exp_data);
    chk({name, "_rsp_code"}, 32'(bus.o_rsp_code), 32'(exp_code));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      garbage_res();
      chk({name, "_hold_valid"}, 32'(bus.o_rsp_valid), 32'd1);
      chk({name, "_hold_data"},  bus.o_rsp_data, exp_data);
      chk({name, "_hold_code"},  32'(bus.o_rsp_code), 32'(exp_code));
      chk({name, "_hold_ready"}, 32'(bus.o_cmd_ready), 32'd0);
    end
    bus.i_rsp_ready = 1'b1;
    @(negedge clk);
    bus.i_rsp_ready = 1'b0;
    chk({name, "_valid_drop"}, 32'(bus.o_rsp_valid), 32'd0);
    chk({name, "_ready_after"}, 32'(bus.o_cmd_ready), 32'd1);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    aresetn = 1'b0;
    bus.i_cmd_valid = 1'b0;
    bus.i_rsp_ready = 1'b0;
    scramble_cmd();
    garbage_res();
    repeat (3) @(negedge clk);
    chk_reset_values("reset");
    chk("reset_state_idle", 32'(dbg_state), 32'd0);
    aresetn = 1'b1;
    @(negedge clk);
    chk("release_ready", 32'(bus.o_cmd_ready), 32'd1);

    run_cmd("lb_signed",  32'h5,  `MEM_COUNT_BYTE, 1'b0, 1'b0, 32'h1234_5678, 32'h80,   `MEM_CODE_READ, 0);
    chk("lb_signed_literal", bus.o_rsp_data, 32'hFFFF_FF80);
    run_cmd("lhu",        32'h2,  `MEM_COUNT_HALF, 1'b0, 1'b1, 32'h0,         32'h8001, `MEM_CODE_READ, 1);
    chk("lhu_literal", bus.o_rsp_data, 32'h0000_8001);
    run_cmd("lw_misal",   32'h6,  `MEM_COUNT_WORD, 1'b0, 1'b0, 32'h0,         32'hAAAA, `MEM_CODE_READ, 0);
    run_cmd("lh_misal",   32'h7,  `MEM_COUNT_HALF, 1'b0, 1'b1, 32'h0,         32'hAAAA, `MEM_CODE_READ, 0);
    run_cmd("cnt_none",   32'h8,  `MEM_COUNT_NONE, 1'b0, 1'b0, 32'h0,         32'hAAAA, `MEM_CODE_READ, 0);
    run_cmd("sw",         32'h10, `MEM_COUNT_WORD, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'h5555, `MEM_CODE_WRITE, 0);
    run_cmd("lw_hold5",   32'h20, `MEM_COUNT_WORD, 1'b0, 1'b0, 32'h0,         32'hCAFE_F00D, `MEM_CODE_READ, 5);
    run_cmd("lw_fault",   32'h24, `MEM_COUNT_WORD, 1'b0, 1'b0, 32'h0,         32'h1111_2222, `MEM_CODE_FAULT, 0);

    // Reset while waiting for the peripheral drops the command entirely.
    @(negedge clk);
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_addr = 32'h40; bus.i_cmd_count = `MEM_COUNT_WORD;
    bus.i_cmd_we = 1'b0; bus.i_cmd_unsigned = 1'b0; bus.i_cmd_wr_data = 32'h0;
    @(negedge clk);
    bus.i_cmd_valid = 1'b0;
    repeat (2) @(negedge clk);   // cycle 3 after acceptance: waiting
    bus.i_res_rd_data = 32'h7777_7777;
    bus.i_res_code = `MEM_CODE_READ;
    aresetn = 1'b0;
    @(negedge clk);
    chk_reset_values("rst_wait");
    aresetn = 1'b1;
    @(negedge clk);
    chk("rst_wait_ready", 32'(bus.o_cmd_ready), 32'd1);
    for (int i = 0; i < 8; i++) begin
      garbage_res();
      @(negedge clk);
      chk("rst_wait_no_valid", 32'(bus.o_rsp_valid), 32'd0);
    end

    // Randomised commands against the model.
    for (int i = 0; i < 25; i++) begin
      logic [1:0]  c;
      logic        w;
      logic [2:0]  rc;
      c  = 2'($urandom_range(0, 3));
      w  = 1'($urandom_range(0, 1));
      rc = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7))
                                       : (w ? `MEM_CODE_WRITE : `MEM_CODE_READ);
      run_cmd("rand", $urandom, c, w, 1'($urandom_range(0, 1)), $urandom, $urandom, rc,
              $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
